// File: rtl/ir_tx.sv
// ir_tx: NEC infrared transmitter. Serialises {~key, key, custom_r, custom_l}
// LSB-first as leader + 32 pulse-distance bits + stop mark, with an optional
// carrier gated onto the LED drive during marks.
module ir_tx #(
  parameter int unsigned LEAD_MARK    = 450000,
  parameter int unsigned LEAD_SPACE   = 225000,
  parameter int unsigned REP_SPACE    = 112500,
  parameter int unsigned BIT_MARK     = 28000,
  parameter int unsigned ZERO_SPACE   = 28000,
  parameter int unsigned ONE_SPACE    = 84500,
  parameter int unsigned CARRIER_HALF = 658,
  parameter int unsigned CARRIER_EN   = 1
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       start_I,
  input  logic       rpt_I,
  input  logic [7:0] custom_l_I,
  input  logic [7:0] custom_r_I,
  input  logic [7:0] key_I,
  output logic       ir_tx_O,
  output logic       env_O,
  output logic       busy_O,
  output logic       done_O,
  output logic [5:0] bit_idx_O
);

  localparam logic [18:0] P_LM  = 19'(LEAD_MARK);
  localparam logic [18:0] P_LS  = 19'(LEAD_SPACE);
  localparam logic [18:0] P_RS  = 19'(REP_SPACE);
  localparam logic [18:0] P_BM  = 19'(BIT_MARK);
  localparam logic [18:0] P_ZS  = 19'(ZERO_SPACE);
  localparam logic [18:0] P_OS  = 19'(ONE_SPACE);
  localparam logic [18:0] P_CH  = 19'(CARRIER_HALF);
  localparam logic        C_EN  = (CARRIER_EN != 0);

  typedef enum logic [2:0] {
    IDLE, LMARK, LSPACE, BMARK, BSPACE, SMARK, FIN
  } state_e;

  state_e      state_q, state_d;
  logic [18:0] cnt_q, cnt_d;
  logic [18:0] ccnt_q, ccnt_d;
  logic        car_q, car_d;
  logic [31:0] frame_q, frame_d;
  logic        rpt_q, rpt_d;
  logic [5:0]  bit_idx_q, bit_idx_d;
  logic [18:0] plen;
  logic        last;
  logic        mark_d;

  logic        ir_q, env_q, busy_q, done_q;
  logic [5:0]  idx_out_q;

  // Phase length of the current state and end-of-phase detect
  always_comb begin
    plen = 19'd1;
    case (state_q)
      LMARK:        plen = P_LM;
      LSPACE:       plen = rpt_q ? P_RS : P_LS;
      BMARK, SMARK: plen = P_BM;
      BSPACE:       plen = frame_q[bit_idx_q[4:0]] ? P_OS : P_ZS;
      default:      plen = 19'd1;
    endcase
    last = (cnt_q == plen - 19'd1);
  end

  // Next-state, frame latch, phase counter and carrier generation
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    rpt_d     = rpt_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: if (start_I) begin
        frame_d   = {~key_I, key_I, custom_r_I, custom_l_I};
        rpt_d     = rpt_I;
        bit_idx_d = 6'd0;
        state_d   = LMARK;
      end
      LMARK:  if (last) state_d = LSPACE;
      LSPACE: if (last) begin
        if (rpt_q) state_d = SMARK;
        else begin
          bit_idx_d = 6'd0;
          state_d   = BMARK;
        end
      end
      BMARK:  if (last) state_d = BSPACE;
      BSPACE: if (last) begin
        if (bit_idx_q == 6'd31) state_d = SMARK;
        else begin
          bit_idx_d = bit_idx_q + 6'd1;
          state_d   = BMARK;
        end
      end
      SMARK:  if (last) state_d = FIN;
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cnt_d  = (state_d != state_q) ? 19'd0 : cnt_q + 19'd1;
    mark_d = (state_d == LMARK) || (state_d == BMARK) || (state_d == SMARK);

    // Every mark begins with the carrier high for a full half period
    ccnt_d = 19'd0;
    car_d  = 1'b0;
    if (mark_d && (state_d != state_q)) begin
      ccnt_d = 19'd0;
      car_d  = 1'b1;
    end else if (mark_d) begin
      if (ccnt_q == P_CH - 19'd1) begin
        ccnt_d = 19'd0;
        car_d  = ~car_q;
      end else begin
        ccnt_d = ccnt_q + 19'd1;
        car_d  = car_q;
      end
    end
  end

  // State, datapath and registered outputs derived from the next state
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ccnt_q    <= '0;
      car_q     <= 1'b0;
      frame_q   <= '0;
      rpt_q     <= 1'b0;
      bit_idx_q <= '0;
      ir_q      <= 1'b0;
      env_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ccnt_q    <= ccnt_d;
      car_q     <= car_d;
      frame_q   <= frame_d;
      rpt_q     <= rpt_d;
      bit_idx_q <= bit_idx_d;
      env_q     <= mark_d;
      ir_q      <= mark_d & (car_d | ~C_EN);
      busy_q    <= (state_d != IDLE) && (state_d != FIN);
      done_q    <= (state_d == FIN);
      idx_out_q <= ((state_d == BMARK) || (state_d == BSPACE)) ? bit_idx_d : 6'd0;
    end
  end

  assign ir_tx_O   = ir_q;
  assign env_O     = env_q;
  assign busy_O    = busy_q;
  assign done_O    = done_q;
  assign bit_idx_O = idx_out_q;

endmodule

// File: tb/tb_ir_tx.sv
// Directed bench for ir_tx using shortened phase lengths so whole frames fit
// in a few hundred cycles. Envelope run lengths are compared against the
// frame structure; carrier, bit index, busy/done and reset are checked too.
`timescale 1ns/1ps
module tb_ir_tx;
  localparam int LM = 20, LS = 10, RS = 5, BM = 3, ZS = 3, OS = 7, CH = 4;
  localparam int MAXC = 2000;

  logic       clk = 1'b0;
  logic       rst, start, rpt;
  logic [7:0] cl, cr, key;
  logic       ir, env, busy, done;
  logic [5:0] idx;
  logic       ir2, env2, busy2, done2;
  logic [5:0] idx2;

  int checks = 0;
  int errors = 0;

  bit env_s[$];
  bit ir_s[$];
  bit ir2_s[$];
  int idx_s[$];
  int runs[$];
  int rstart[$];
  int busy_n, done_n;
  bit got_done, injected;

  always #5 clk = ~clk;

  ir_tx #(.LEAD_MARK(LM), .LEAD_SPACE(LS), .REP_SPACE(RS), .BIT_MARK(BM),
          .ZERO_SPACE(ZS), .ONE_SPACE(OS), .CARRIER_HALF(CH), .CARRIER_EN(1)) dut (
    .CLOCK_50(clk), .rst(rst), .start_I(start), .rpt_I(rpt),
    .custom_l_I(cl), .custom_r_I(cr), .key_I(key),
    .ir_tx_O(ir), .env_O(env), .busy_O(busy), .done_O(done), .bit_idx_O(idx));

  ir_tx #(.LEAD_MARK(LM), .LEAD_SPACE(LS), .REP_SPACE(RS), .BIT_MARK(BM),
          .ZERO_SPACE(ZS), .ONE_SPACE(OS), .CARRIER_HALF(CH), .CARRIER_EN(0)) dut2 (
    .CLOCK_50(clk), .rst(rst), .start_I(start), .rpt_I(rpt),
    .custom_l_I(cl), .custom_r_I(cr), .key_I(key),
    .ir_tx_O(ir2), .env_O(env2), .busy_O(busy2), .done_O(done2), .bit_idx_O(idx2));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // mode 0: plain frame, 1: extra start at bit 5 mark, 2: reset at bit 20 space
  task automatic send(input logic [7:0] l, input logic [7:0] r, input logic [7:0] k,
                      input logic rp, input int mode);
    env_s.delete(); ir_s.delete(); ir2_s.delete(); idx_s.delete();
    busy_n = 0; done_n = 0; got_done = 0; injected = 0;
    cl = l; cr = r; key = k; rpt = rp; start = 1'b1;
    step();
    start = 1'b0;
    cl = ~l; cr = ~r; key = ~k; rpt = ~rp;
    for (int c = 0; c < MAXC; c++) begin
      env_s.push_back(env); ir_s.push_back(ir); ir2_s.push_back(ir2);
      idx_s.push_back(int'(idx));
      if (busy) busy_n++;
      if (done) done_n++;
      if (done) begin got_done = 1; break; end
      if (mode == 1 && !injected && idx == 6'd5 && env) begin start = 1'b1; injected = 1; end
      if (mode == 2 && !injected && idx == 6'd20 && !env) begin rst = 1'b1; injected = 1; break; end
      step();
      start = 1'b0;
    end
  endtask

  // Compare the captured frame with the structure implied by its 32 bits
  task automatic analyze(input string tag, input logic [31:0] f, input logic rp,
                         input int exp_busy);
    int exp_r[$];
    int n, len, bad_ir, bad_ir2, bad_idx, bad_start;
    bit cur;
    chk({tag, "_done_seen"}, int'(got_done), 1);
    chk({tag, "_done_cnt"}, done_n, 1);
    chk({tag, "_busy_len"}, busy_n, exp_busy);
    n = env_s.size() - 1;
    runs.delete(); rstart.delete();
    cur = env_s[0]; len = 0; rstart.push_back(0);
    for (int i = 0; i < n; i++) begin
      if (env_s[i] == cur) len++;
      else begin runs.push_back(len); rstart.push_back(i); cur = env_s[i]; len = 1; end
    end
    runs.push_back(len);
    chk({tag, "_first_env"}, int'(env_s[0]), 1);
    exp_r.push_back(LM);
    exp_r.push_back(rp ? RS : LS);
    if (!rp) for (int b = 0; b < 32; b++) begin
      exp_r.push_back(BM);
      exp_r.push_back(f[b] ? OS : ZS);
    end
    exp_r.push_back(BM);
    chk({tag, "_run_count"}, runs.size(), exp_r.size());
    if (runs.size() == exp_r.size())
      for (int i = 0; i < runs.size(); i++)
        chk($sformatf("%s_run%0d", tag, i), runs[i], exp_r[i]);
    bad_ir = 0; bad_ir2 = 0; bad_idx = 0; bad_start = 0;
    for (int i = 0; i < env_s.size(); i++) begin
      if (!env_s[i] && ir_s[i]) bad_ir++;
      if (ir2_s[i] != env_s[i]) bad_ir2++;
    end
    for (int i = 0; i < rstart.size(); i++)
      if (env_s[rstart[i]] && !ir_s[rstart[i]]) bad_start++;
    if (rp) begin
      for (int i = 0; i < idx_s.size(); i++) if (idx_s[i] != 0) bad_idx++;
    end else if (runs.size() == exp_r.size()) begin
      for (int b = 0; b < 32; b++) begin
        if (idx_s[rstart[2 + 2*b]] != b) bad_idx++;
        if (idx_s[rstart[3 + 2*b]] != b) bad_idx++;
      end
    end
    chk({tag, "_ir_in_space"}, bad_ir, 0);
    chk({tag, "_noncarrier_eq_env"}, bad_ir2, 0);
    chk({tag, "_mark_starts_high"}, bad_start, 0);
    chk({tag, "_bit_idx"}, bad_idx, 0);
  endtask

  initial begin
    int bad;
    logic [31:0] dec;
    rst = 1'b1; start = 1'b0; rpt = 1'b0; cl = '0; cr = '0; key = '0;
    step(); step();
    chk("rst_env", int'(env), 0);
    chk("rst_ir", int'(ir), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_idx", int'(idx), 0);
    rst = 1'b0;
    step();

    // Data frame 0x00/0xFF/0x16: k = 16 -> 20+10+96+16*7+16*3+3 = 289
    send(8'h00, 8'hFF, 8'h16, 1'b0, 0);
    analyze("data", 32'hE916FF00, 1'b0, 289);
    if (runs.size() == 67) begin
      chk("bit16_space", runs[3 + 32], ZS);
      chk("bit17_space", runs[3 + 34], OS);
    end else chk("bit16_17_runs_present", runs.size(), 67);
    // Leader carrier: 4 high, 4 low, ...
    bad = 0;
    for (int c = 0; c < LM; c++) if (ir_s[c] != (((c / CH) % 2) == 0)) bad++;
    chk("leader_carrier", bad, 0);
    step();
    chk("idle_after_done", int'(done), 0);
    chk("idle_busy", int'(busy), 0);

    // Loopback-style decode of 0x04/0xFB/0x45 (k = 1+7+8 = 16)
    send(8'h04, 8'hFB, 8'h45, 1'b0, 0);
    analyze("loop", 32'hBA45FB04, 1'b0, 289);
    dec = '0;
    if (runs.size() == 67)
      for (int b = 0; b < 32; b++) dec[b] = (runs[3 + 2*b] > (ZS + OS) / 2);
    chk("loop_decode", int'(dec), int'(32'hBA45FB04));
    step();

    // Repeat frame: 20 high, 5 low, 3 high -> 28
    send(8'hA5, 8'h5A, 8'h3C, 1'b1, 0);
    analyze("rep", 32'h0, 1'b1, 28);
    step();

    // Start during bit 5 mark is ignored; a start right after done is taken
    send(8'h00, 8'hFF, 8'h16, 1'b0, 1);
    chk("busy_start_injected", int'(injected), 1);
    analyze("busystart", 32'hE916FF00, 1'b0, 289);
    step();
    send(8'h04, 8'hFB, 8'h45, 1'b0, 0);
    analyze("backtoback", 32'hBA45FB04, 1'b0, 289);
    step();

    // Reset during bit 20 space
    send(8'h00, 8'hFF, 8'h16, 1'b0, 2);
    chk("mid_rst_reached", int'(injected), 1);
    step();
    rst = 1'b0;
    chk("mid_rst_env", int'(env), 0);
    chk("mid_rst_ir", int'(ir), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_idx", int'(idx), 0);
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done || busy || env) bad++;
    end
    chk("mid_rst_quiet", bad, 0);
    send(8'h00, 8'hFF, 8'h16, 1'b0, 0);
    analyze("after_rst", 32'hE916FF00, 1'b0, 289);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ir_tx.md
# ir_tx

NEC-protocol infrared transmitter running on the 50 MHz board clock. It accepts a 16-bit custom code and an 8-bit key, generates the inverted key itself, and serialises the 32-bit frame LSB-first. Output is the standard leader, 32 pulse-distance bits and a stop mark, with an optional 38 kHz carrier on the LED drive. It is the transmit counterpart of the IRDA receive path and can be looped back into it for self-test.

## Interface
- LEAD_MARK, 450000: leader mark length in cycles (9 ms).
- LEAD_SPACE, 225000: leader space for a data frame (4.5 ms).
- REP_SPACE, 112500: leader space for a repeat frame (2.25 ms).
- BIT_MARK, 28000: mark length for every data bit and the stop mark (560 us).
- ZERO_SPACE, 28000: space after a mark for a 0 bit (560 us).
- ONE_SPACE, 84500: space after a mark for a 1 bit (1.69 us ×1000 = 1690 us).
- CARRIER_HALF, 658: carrier half-period in cycles (about 38 kHz).
- CARRIER_EN, 1: 1 modulates marks with the carrier; 0 drives marks as a steady high.

Ports (clock and reset first):
- CLOCK_50 — in, 1 — the single clock.
- rst — in, 1 — synchronous, active-high reset.
- start_I — in, 1 — one-cycle request; sampled only in IDLE.
- rpt_I — in, 1 — sampled with start_I; 1 selects a repeat frame, 0 a data frame.
- custom_l_I — in, 8 — custom low byte; frame bits 0-7.
- custom_r_I — in, 8 — custom high byte; frame bits 8-15.
- key_I — in, 8 — key byte; frame bits 16-23. Bits 24-31 are ~key_I.
- ir_tx_O — out, 1 — LED drive, active-high; carrier-modulated during marks when CARRIER_EN=1.
- env_O — out, 1 — unmodulated envelope: 1 during a mark, 0 during a space or idle.
- busy_O — out, 1 — high from the cycle after start is accepted until the end of the stop mark.
- done_O — out, 1 — one-cycle pulse when a frame completes.
- bit_idx_O — out, 6 — index of the bit currently being sent (0-31); 0 outside data bits.

## Operation
- States: IDLE, LMARK, LSPACE, BMARK, BSPACE, SMARK, FIN.
- IDLE:
  - On start_I=1, latch frame[31:0] = {~key_I, key_I, custom_r_I, custom_l_I} and latch rpt_I.
  - Clear the phase counter and go to LMARK.
- LMARK lasts LEAD_MARK cycles, then goes to LSPACE.
- LSPACE lasts REP_SPACE cycles if rpt is latched, otherwise LEAD_SPACE cycles.
  - Repeat frame: go to SMARK.
  - Data frame: set bit_idx=0 and go to BMARK.
- BMARK lasts BIT_MARK cycles, then goes to BSPACE.
- BSPACE lasts ONE_SPACE cycles if frame[bit_idx]=1, otherwise ZERO_SPACE cycles.
  - If bit_idx=31, go to SMARK.
  - Otherwise increment bit_idx and go to BMARK.
- SMARK lasts BIT_MARK cycles, then goes to FIN.
- FIN lasts one cycle: done_O=1, busy_O=0, then return to IDLE.
- Phase counter:
  - 19 bits, counting 0 to N-1 within a phase.
  - The transition occurs on the cycle where the count equals N-1; the count is cleared on every state change.
  - Every parameter must be below 2^19.
- Carrier:
  - Counter cleared at each mark entry so every mark starts with the carrier high.
  - Toggles after every CARRIER_HALF cycles.
  - ir_tx_O = env_O & (carrier | ~CARRIER_EN).
- Start handling: start_I outside IDLE is ignored and not queued. Inputs may change freely after acceptance.
- Reset: rst=1 at any time, including mid-frame, forces IDLE on the next edge.
- Reset values: ir_tx_O=0, env_O=0, busy_O=0, done_O=0, bit_idx_O=0; frame register=0.

## Timing
- All outputs are registered.
- start_I is sampled at edge t. At edge t+1: state=LMARK, env_O=1, busy_O=1.
- Each phase holds its state for exactly N cycles.
- Data frame length, for k one-bits in the 32-bit frame: LEAD_MARK + LEAD_SPACE + 32·BIT_MARK + k·ONE_SPACE + (32−k)·ZERO_SPACE + BIT_MARK.
- Repeat frame length: LEAD_MARK + REP_SPACE + BIT_MARK = 590500 cycles.
- done_O pulses in the cycle immediately after the last SMARK cycle. A new start_I is accepted in the following cycle (IDLE).
- k is always 8 + popcount(custom bytes): the key and its inverse contribute exactly 8 ones.

## Test plan
- Data frame: custom_l=0x00, custom_r=0xFF, key=0x16 (k=16).
  - Required: busy_O high for exactly 3,399,000 cycles; done_O pulses once.
  - Required: env_O edge times match the formula; bit 16 uses a 28000-cycle space, bit 17 an 84500-cycle space.
- Loopback: ~env_O drives IRDA_RXD of the team's receiver, with custom_l=0x04, custom_r=0xFB, key=0x45.
  - Required: the receiver nibbles decode to 0x04/0xFB/0x45/0xBA.
- Repeat frame: start_I with rpt_I=1.
  - Required: env_O pattern is 450000 high, 112500 low, 28000 high; busy_O high for 590500 cycles; bit_idx_O stays 0.
- Carrier: CARRIER_EN=1 during the leader mark.
  - Required: ir_tx_O high for 658 cycles, low for 658, and so on; ir_tx_O=0 throughout every space.
  - With CARRIER_EN=0: ir_tx_O equals env_O.
- Busy start: pulse start_I during BMARK with bit_idx=5.
  - Required: frame timing is unchanged and only one done_O pulse occurs.
  - A start_I in the cycle after done_O begins a new frame.
- Reset: assert rst for one cycle during BSPACE at bit 20.
  - Required: the next edge gives all outputs at 0 and state IDLE, with no done_O pulse.
  - A subsequent start_I sends a full correct frame.
